branch_redirect_ctrl: RTL
=========================

Name: branch_redirect_ctrl

Overview:
- Memory-stage redirect controller that sits directly downstream of the branch comparator/resolve logic.
- Qualifies the per-branch resolve flag with MEM-stage valid and jump info, then squashes wrong-path instructions (predict-not-taken pipeline).
- Holds a PC redirect toward fetch under a valid/ready handshake.
- Flags misaligned targets and counts taken control transfers.

Parameters:
- XLEN, 32: width of PC/target and redirect_pc.
- CNT_W, 32: width of taken_count.
- DRAIN_CYCLES, 1: extra cycles flush_if_id stays high after fetch accepts a redirect (fetch latency cover); legal range 0..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_valid  in  1  MEM-stage instruction valid.
- mem_is_branch  in  1  MEM instruction is a conditional branch.
- mem_is_jump  in  1  MEM instruction is JAL/JALR (always taken).
- resolve  in  1  branch-condition result; meaningful only when mem_is_branch=1.
- mem_target  in  XLEN  computed control-transfer target.
- fetch_ready  in  1  fetch accepts redirect this cycle.
- redirect_valid  out  1  redirect request to fetch.
- redirect_pc  out  XLEN  redirect target.
- flush_if_id  out  1  squash IF/ID register.
- flush_id_ex  out  1  squash ID/EX register.
- flush_ex_mem  out  1  squash EX/MEM register.
- misalign_exc  out  1  one-cycle pulse: taken target not 4-byte aligned.
- taken_count  out  CNT_W  count of redirects issued, wraps.

Behaviour:
- Reset (asynchronous, active-high; applies at any time, including mid-operation):
  - state=IDLE; redirect_valid=0; redirect_pc=0; misalign_exc=0; taken_count=0; drain counter=0.
  - Any pending redirect is dropped.
- taken (combinational) = mem_valid & ((mem_is_branch & resolve) | mem_is_jump). resolve is ignored, even if X, when mem_is_branch=0.
- States: IDLE, REDIRECT, DRAIN.
- IDLE:
  - If taken in cycle T: flush_if_id, flush_id_ex and flush_ex_mem are asserted combinationally in T.
  - If taken in T and mem_target[1:0]==0:
    - Next state is REDIRECT.
    - redirect_pc <= mem_target and redirect_valid <= 1, both visible from T+1.
    - taken_count increments, visible at T+1.
  - If taken in T and mem_target[1:0]!=0:
    - No redirect; state stays IDLE; taken_count unchanged.
    - misalign_exc=1 for exactly cycle T+1.
  - No taken: all flush outputs=0.
- REDIRECT:
  - redirect_valid=1; redirect_pc stable; flush_if_id=1 and flush_id_ex=1; flush_ex_mem=0.
  - When fetch_ready=1, the transfer completes at that edge:
    - DRAIN_CYCLES>0: go to DRAIN with counter=DRAIN_CYCLES.
    - DRAIN_CYCLES=0: go to IDLE.
  - fetch_ready is allowed in the first REDIRECT cycle, giving a one-cycle handshake.
  - redirect_valid deasserts the cycle after acceptance.
- DRAIN:
  - flush_if_id=1; other flushes=0; redirect_valid=0.
  - Counter decrements each cycle; go to IDLE when it reaches 1→0.
- taken while in REDIRECT/DRAIN: cannot occur legally, because MEM holds flushed bubbles.
  - It is ignored: no state change, no count.
  - A simulation assertion flags it.
- taken_count wraps from 2^CNT_W-1 to 0 with no saturation.
- misalign_exc never coincides with redirect_valid rising.

Test Plan:
- Taken BEQ: mem_valid=1, mem_is_branch=1, resolve=1, mem_target=0x0000_0100 at T, fetch_ready=1 at T+1 -> all three flushes=1 in T; redirect_valid=1 and redirect_pc=0x100 at T+1 only; flush_if_id=1 at T+2 (DRAIN_CYCLES=1); IDLE at T+3; taken_count=1.
- Not-taken branch: resolve=0, mem_is_branch=1 -> no flush, redirect_valid=0, taken_count unchanged. Repeat with resolve=X -> same result.
- Backpressure: JAL with target 0x2000, fetch_ready=0 for 3 cycles then 1 -> redirect_valid held 4 cycles with redirect_pc=0x2000 stable; flush_if_id/id_ex high throughout.
- Misaligned: branch taken with target 0x0000_0102 -> flushes in T, misalign_exc=1 at T+1 only, redirect_valid stays 0, taken_count unchanged.
- Reset mid-REDIRECT: assert rst asynchronously while redirect_valid=1 -> redirect_valid, taken_count and flushes drop to 0 immediately; after release, a new taken branch is handled normally.
- Counter wrap: CNT_W=4, 16 taken jumps each accepted immediately -> taken_count returns to 0.

Source files
------------

// File: rtl/branch_redirect_ctrl.sv
// MEM-stage redirect controller: qualifies resolved branches/jumps, squashes
// wrong-path instructions and hands a PC redirect to fetch under valid/ready.
module branch_redirect_ctrl #(
  parameter int XLEN         = 32,
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_valid,
  input  logic            mem_is_branch,
  input  logic            mem_is_jump,
  input  logic            resolve,
  input  logic [XLEN-1:0] mem_target,
  input  logic            fetch_ready,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            flush_ex_mem,
  output logic            misalign_exc,
  output logic [CNT_W-1:0] taken_count
);

  // Handshake: redirect_valid holds with a stable redirect_pc until a cycle
  // with fetch_ready=1; the transfer completes at that rising edge.

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    DRAIN    = 2'd2
  } state_t;

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        drain_q, drain_d;
  logic              misalign_q, misalign_d;
  logic              taken;
  logic              target_misaligned;

  // resolve only matters for conditional branches, so it is gated first.
  assign taken             = mem_valid & ((mem_is_branch & resolve) | mem_is_jump);
  assign target_misaligned = |mem_target[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      cnt_q      <= '0;
      drain_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      drain_q    <= drain_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    cnt_d        = cnt_q;
    drain_d      = drain_q;
    misalign_d   = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (taken) begin
          flush_if_id  = 1'b1;
          flush_id_ex  = 1'b1;
          flush_ex_mem = 1'b1;
          if (target_misaligned) begin
            misalign_d = 1'b1;
          end else begin
            state_d = REDIRECT;
            pc_d    = mem_target;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      REDIRECT: begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        if (fetch_ready) begin
          if (DRAIN_CYCLES > 0) begin
            state_d = DRAIN;
            drain_d = DRAIN_INIT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        flush_if_id = 1'b1;
        drain_d     = drain_q - 4'd1;
        if (drain_q <= 4'd1) begin
          state_d = IDLE;
          drain_d = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign redirect_valid = (state_q == REDIRECT);
  assign redirect_pc    = pc_q;
  assign misalign_exc   = misalign_q;
  assign taken_count    = cnt_q;

  // MEM holds flushed bubbles while a redirect is in flight.
  a_no_taken_busy: assert property (@(posedge clk) disable iff (rst)
    !(taken && (state_q != IDLE)));

endmodule
